rf_wport_arbiter: RTL and testbench

//  Owns the single register-file write port. WB stage writeback always wins; a long-latency unit (LU: divider,

---
 rtl/rf_wport_arbiter.sv | 122 ++++++++++++
 tb/tb_rf_wport_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single register-file write port between WB writeback and a queued
// long-latency unit, tracks pending LU destinations and forces a WB bubble on starvation.
module rf_wport_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [37:0] ws_to_rf_bus,
  input  logic        lu_issue_valid,
  input  logic [4:0]  lu_issue_dest,
  input  logic        lu_req_valid,
  output logic        lu_req_ready,
  input  logic [4:0]  lu_req_dest,
  input  logic [31:0] lu_req_data,
  output logic        ms_hold,
  input  logic [4:0]  ds_rs,
  input  logic [4:0]  ds_rt,
  output logic        ds_rs_busy,
  output logic        ds_rt_busy,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        err_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef logic [AW:0] ptr_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= LIMIT_C) ? v : CW'(v + 1'b1);
  endfunction

  logic        ws_we;
  logic [4:0]  ws_addr;
  logic [31:0] ws_data;
  assign {ws_we, ws_addr, ws_data} = ws_to_rf_bus;

  logic [4:0]  fifo_dest [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  ptr_t        wptr, rptr;
  logic        empty, full;
  logic [31:0] pend, pend_next, set_vec, clr_vec;
  logic [CW-1:0] starve_cnt, starve_next;

  logic        pop, byp, drain, push;
  logic [4:0]  drain_dest;
  logic [31:0] drain_data;
  logic        err_issue, err_res, err_waw;

  // Full when the wrap bits differ but the index bits match
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign lu_req_ready = !full;

  always_comb begin
    pop        = 1'b0;
    byp        = 1'b0;
    drain_dest = lu_req_dest;
    drain_data = lu_req_data;
    if (!ws_we && !empty) begin
      pop        = 1'b1;
      drain_dest = fifo_dest[rptr[AW-1:0]];
      drain_data = fifo_data[rptr[AW-1:0]];
    end else if (!ws_we && lu_req_valid) begin
      byp = 1'b1;
    end
  end

  assign drain = pop | byp;
  assign push  = lu_req_valid && lu_req_ready && !byp;

  // $0 writes are consumed (and drained) but never reach the RF
  assign rf_we    = resetn && (ws_we ? (ws_addr != 5'd0) : (drain && (drain_dest != 5'd0)));
  assign rf_waddr = ws_we ? ws_addr : drain_dest;
  assign rf_wdata = ws_we ? ws_data : drain_data;

  assign set_vec   = (lu_issue_valid && (lu_issue_dest != 5'd0)) ? (32'd1 << lu_issue_dest) : 32'd0;
  assign clr_vec   = drain ? (32'd1 << drain_dest) : 32'd0;
  assign pend_next = (pend & ~clr_vec) | set_vec;

  assign ds_rs_busy = (ds_rs != 5'd0) && pend[ds_rs];
  assign ds_rt_busy = (ds_rt != 5'd0) && pend[ds_rt];

  assign err_issue = lu_issue_valid && (lu_issue_dest != 5'd0) && pend[lu_issue_dest]
                     && !(drain && (drain_dest == lu_issue_dest));
  assign err_res   = (byp || push) && (lu_req_dest != 5'd0) && !pend[lu_req_dest]
                     && !(lu_issue_valid && (lu_issue_dest == lu_req_dest));
  assign err_waw   = ws_we && (ws_addr != 5'd0) && pend[ws_addr];

  assign starve_next = (empty || pop) ? '0 : sat_inc(starve_cnt);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      pend       <= '0;
      starve_cnt <= '0;
      ms_hold    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (push) wptr <= wptr + ptr_t'(1);
      if (pop)  rptr <= rptr + ptr_t'(1);
      pend       <= pend_next;
      starve_cnt <= starve_next;
      ms_hold    <= (starve_next >= LIMIT_C);
      if (err_issue || err_res || err_waw) err_sticky <= 1'b1;
    end
  end

  // FIFO payload needs no reset; validity lives in the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest[wptr[AW-1:0]] <= lu_req_dest;
      fifo_data[wptr[AW-1:0]] <= lu_req_data;
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: a table of per-cycle vectors plus hand-written
// sequences for starvation, error flags and mid-queue reset.
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [37:0] ws_to_rf_bus;
  logic        lu_issue_valid;
  logic [4:0]  lu_issue_dest;
  logic        lu_req_valid;
  logic        lu_req_ready;
  logic [4:0]  lu_req_dest;
  logic [31:0] lu_req_data;
  logic        ms_hold;
  logic [4:0]  ds_rs, ds_rt;
  logic        ds_rs_busy, ds_rt_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err_sticky;

  int n_chk  = 0;
  int n_fail = 0;

  rf_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn), .ws_to_rf_bus(ws_to_rf_bus),
    .lu_issue_valid(lu_issue_valid), .lu_issue_dest(lu_issue_dest),
    .lu_req_valid(lu_req_valid), .lu_req_ready(lu_req_ready),
    .lu_req_dest(lu_req_dest), .lu_req_data(lu_req_data),
    .ms_hold(ms_hold), .ds_rs(ds_rs), .ds_rt(ds_rt),
    .ds_rs_busy(ds_rs_busy), .ds_rt_busy(ds_rt_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wwe;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  id;
    logic        rv;
    logic [4:0]  rd;
    logic [31:0] rdat;
    logic [4:0]  rs, rt;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rdy, e_hold, e_rsb, e_rtb, e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
    input logic iv, input logic [4:0] id,
    input logic rv, input logic [4:0] rd, input logic [31:0] rdat,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic e_we, input logic [4:0] e_addr, input logic [31:0] e_data,
    input logic e_rdy, input logic e_hold, input logic e_rsb, input logic e_rtb, input logic e_err);
    vec_t v;
    v.wwe = wwe; v.wa = wa; v.wd = wd; v.iv = iv; v.id = id;
    v.rv = rv; v.rd = rd; v.rdat = rdat; v.rs = rs; v.rt = rt;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
    v.e_rdy = e_rdy; v.e_hold = e_hold; v.e_rsb = e_rsb; v.e_rtb = e_rtb; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                       input logic iv, input logic [4:0] id,
                       input logic rv, input logic [4:0] rd, input logic [31:0] rdat,
                       input logic [4:0] rs, input logic [4:0] rt);
    ws_to_rf_bus   = {wwe, wa, wd};
    lu_issue_valid = iv;
    lu_issue_dest  = id;
    lu_req_valid   = rv;
    lu_req_dest    = rd;
    lu_req_data    = rdat;
    ds_rs          = rs;
    ds_rt          = rt;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  vec_t tbl[22];

  initial begin
    tbl[0]  = mk(0,0,0,          0,0,  0,0,0,             0,0,   0,0,0,             1,0,0,0,0);
    tbl[1]  = mk(1,5,32'hA5A5A5A5, 0,0, 0,0,0,            0,0,   1,5,32'hA5A5A5A5,  1,0,0,0,0);
    tbl[2]  = mk(0,0,0,          1,8,  0,0,0,             8,0,   0,0,0,             1,0,0,0,0);
    tbl[3]  = mk(0,0,0,          0,0,  0,0,0,             8,0,   0,0,0,             1,0,1,0,0);
    tbl[4]  = mk(0,0,0,          0,0,  0,0,0,             8,0,   0,0,0,             1,0,1,0,0);
    tbl[5]  = mk(0,0,0,          0,0,  1,8,32'h11,        8,0,   1,8,32'h11,        1,0,1,0,0);
    tbl[6]  = mk(0,0,0,          0,0,  0,0,0,             8,0,   0,0,0,             1,0,0,0,0);
    tbl[7]  = mk(0,0,0,          1,9,  0,0,0,             0,9,   0,0,0,             1,0,0,0,0);
    tbl[8]  = mk(1,3,32'h33,     0,0,  1,9,32'h99,        0,9,   1,3,32'h33,        1,0,0,1,0);
    tbl[9]  = mk(1,4,32'h44,     0,0,  0,0,0,             0,9,   1,4,32'h44,        1,0,0,1,0);
    tbl[10] = mk(0,0,0,          0,0,  0,0,0,             0,9,   1,9,32'h99,        1,0,0,1,0);
    tbl[11] = mk(0,0,0,          0,0,  0,0,0,             0,9,   0,0,0,             1,0,0,0,0);
    tbl[12] = mk(0,0,0,          1,10, 0,0,0,             0,0,   0,0,0,             1,0,0,0,0);
    tbl[13] = mk(0,0,0,          1,11, 0,0,0,             0,0,   0,0,0,             1,0,0,0,0);
    tbl[14] = mk(1,1,32'h1,      1,12, 1,10,32'hA0,       0,0,   1,1,32'h1,         1,0,0,0,0);
    tbl[15] = mk(1,2,32'h2,      0,0,  1,11,32'hB0,       0,0,   1,2,32'h2,         1,0,0,0,0);
    tbl[16] = mk(1,1,32'h3,      0,0,  1,12,32'hC0,       0,0,   1,1,32'h3,         0,0,0,0,0);
    tbl[17] = mk(0,0,0,          0,0,  1,12,32'hC0,       10,11, 1,10,32'hA0,       0,0,1,1,0);
    tbl[18] = mk(0,0,0,          0,0,  1,12,32'hC0,       10,11, 1,11,32'hB0,       1,0,0,1,0);
    tbl[19] = mk(0,0,0,          0,0,  0,0,0,             12,0,  1,12,32'hC0,       1,0,1,0,0);
    tbl[20] = mk(0,0,0,          0,0,  0,0,0,             12,0,  0,0,0,             1,0,0,0,0);
    tbl[21] = mk(1,0,32'hFF,     0,0,  0,0,0,             0,0,   0,0,0,             1,0,0,0,0);

    // Reset, with a WB write presented that must not reach the RF
    resetn = 1'b0;
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_ready", {31'd0, lu_req_ready}, 32'd1);
    chk("rst_hold",  {31'd0, ms_hold}, 32'd0);
    chk("rst_err",   {31'd0, err_sticky}, 32'd0);
    repeat (2) @(negedge clk);
    idle();
    resetn = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i].wwe, tbl[i].wa, tbl[i].wd, tbl[i].iv, tbl[i].id,
            tbl[i].rv, tbl[i].rd, tbl[i].rdat, tbl[i].rs, tbl[i].rt);
      #1;
      chk($sformatf("row%0d_we", i), {31'd0, rf_we}, {31'd0, tbl[i].e_we});
      if (tbl[i].e_we) begin
        chk($sformatf("row%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, tbl[i].e_addr});
        chk($sformatf("row%0d_wdata", i), rf_wdata, tbl[i].e_data);
      end
      chk($sformatf("row%0d_ready", i), {31'd0, lu_req_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("row%0d_hold", i),  {31'd0, ms_hold},      {31'd0, tbl[i].e_hold});
      chk($sformatf("row%0d_rsbusy", i), {31'd0, ds_rs_busy},  {31'd0, tbl[i].e_rsb});
      chk($sformatf("row%0d_rtbusy", i), {31'd0, ds_rt_busy},  {31'd0, tbl[i].e_rtb});
      chk($sformatf("row%0d_err", i),   {31'd0, err_sticky},   {31'd0, tbl[i].e_err});
    end

    // Starvation: one queued entry, WB busy every cycle until ms_hold forces a bubble
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 5'd6, 32'h6, 1'b0, 5'd0, 1'b1, 5'd13, 32'hD0, 5'd0, 5'd0);
    #1 chk("starve_enq_ready", {31'd0, lu_req_ready}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive(1'b1, 5'd7, k, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
      #1;
      chk($sformatf("starve_c%0d_hold", k), {31'd0, ms_hold}, 32'd0);
      chk($sformatf("starve_c%0d_waddr", k), {27'd0, rf_waddr}, 32'd7);
      chk($sformatf("starve_c%0d_busy", k), {31'd0, ds_rs_busy}, 32'd1);
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd0);
    #1;
    chk("starve_hold_on", {31'd0, ms_hold}, 32'd1);
    chk("starve_drain_we", {31'd0, rf_we}, 32'd1);
    chk("starve_drain_waddr", {27'd0, rf_waddr}, 32'd13);
    chk("starve_drain_wdata", rf_wdata, 32'hD0);
    @(negedge clk);
    idle();
    ds_rs = 5'd13;
    #1;
    chk("starve_hold_off", {31'd0, ms_hold}, 32'd0);
    chk("starve_idle_we", {31'd0, rf_we}, 32'd0);
    chk("starve_busy_clr", {31'd0, ds_rs_busy}, 32'd0);
    chk("starve_err", {31'd0, err_sticky}, 32'd0);

    // Double issue sets the error; reset mid-queue clears everything
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1 chk("dbl_issue_err_pre", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    drive(1'b1, 5'd6, 32'h6, 1'b0, 5'd0, 1'b1, 5'd4, 32'h4444, 5'd4, 5'd0);
    #1 chk("dbl_issue_err", {31'd0, err_sticky}, 32'd1);
    @(negedge clk);
    drive(1'b1, 5'd6, 32'h7, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    #1 chk("mid_queue_busy", {31'd0, ds_rs_busy}, 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rst_mid_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_mid_busy", {31'd0, ds_rs_busy}, 32'd0);
    chk("rst_mid_err", {31'd0, err_sticky}, 32'd0);
    chk("rst_mid_ready", {31'd0, lu_req_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    idle();
    ds_rs = 5'd4;
    #1;
    chk("post_rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("post_rst_busy", {31'd0, ds_rs_busy}, 32'd0);
    chk("post_rst_hold", {31'd0, ms_hold}, 32'd0);

    // WB write to a pending destination
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 5'd20, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1 chk("waw_err_pre", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    idle();
    #1 chk("waw_err", {31'd0, err_sticky}, 32'd1);

    // LU result with no pending destination still writes, but flags
    do_reset();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd21, 32'h5, 5'd0, 5'd0);
    #1;
    chk("orphan_err_pre", {31'd0, err_sticky}, 32'd0);
    chk("orphan_we", {31'd0, rf_we}, 32'd1);
    chk("orphan_waddr", {27'd0, rf_waddr}, 32'd21);
    @(negedge clk);
    idle();
    #1 chk("orphan_err", {31'd0, err_sticky}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
